// File: rtl/delay_tap_mixer.sv
// Wet/feedback mixer for the SRAM single-tap delay line.
// One shared 20x8 multiplier, fixed 4-cycle latency per sample.
module delay_tap_mixer #(
  parameter logic [19:0] SAT_MAX = 20'h7FFFF,
  parameter logic [19:0] SAT_MIN = 20'h80000
) (
  input  logic        CLOCK50,
  input  logic        RESET,
  input  logic        SAMPLE_STB,
  input  logic [19:0] AudioIn,
  input  logic [15:0] TapIn,
  input  logic        TapValid,
  input  logic [7:0]  WetGain,
  input  logic [7:0]  FeedbackGain,
  output logic [19:0] AudioOut,
  output logic [15:0] WriteData,
  output logic        OutValid,
  output logic        ClipFlag,
  output logic        Busy,
  output logic        Overrun
);

  typedef enum logic [1:0] {
    IDLE,
    MUL_WET,
    MUL_FB,
    SUM
  } state_t;

  state_t state, nextState;

  logic [19:0]        audioR;
  logic signed [19:0] tapR;
  logic [7:0]         wetGainR;
  logic [7:0]         fbGainR;
  logic signed [20:0] wetP;
  logic signed [20:0] fbP;

  logic               accept;
  logic signed [8:0]  gainS;
  logic signed [28:0] prod;
  logic signed [20:0] mulOut;
  logic signed [20:0] sumWet;
  logic signed [20:0] sumFb;
  logic [19:0]        satWet;
  logic [19:0]        satFb;
  logic               clipWet;
  logic               clipFb;

  function automatic logic [19:0] sat(input logic [20:0] s);
    if (s[20] != s[19]) begin
      return s[20] ? SAT_MIN : SAT_MAX;
    end
    return s[19:0];
  endfunction

  assign accept = (state == IDLE) && SAMPLE_STB;
  assign Busy   = (state != IDLE);

  // The single multiplier serves the wet gain first, then the feedback gain
  assign gainS  = $signed({1'b0, (state == MUL_FB) ? fbGainR : wetGainR});
  assign prod   = tapR * gainS;
  assign mulOut = 21'(prod >>> 8);

  assign sumWet  = $signed({audioR[19], audioR}) + wetP;
  assign sumFb   = $signed({audioR[19], audioR}) + fbP;
  assign clipWet = sumWet[20] ^ sumWet[19];
  assign clipFb  = sumFb[20] ^ sumFb[19];
  assign satWet  = sat(sumWet);
  assign satFb   = sat(sumFb);

  always_ff @(posedge CLOCK50 or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (SAMPLE_STB) nextState = MUL_WET;
      MUL_WET: nextState = MUL_FB;
      MUL_FB:  nextState = SUM;
      SUM:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK50 or posedge RESET) begin
    if (RESET) begin
      audioR    <= '0;
      tapR      <= '0;
      wetGainR  <= '0;
      fbGainR   <= '0;
      wetP      <= '0;
      fbP       <= '0;
      AudioOut  <= '0;
      WriteData <= '0;
      OutValid  <= 1'b0;
      ClipFlag  <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      OutValid <= 1'b0;
      if (SAMPLE_STB && Busy) begin
        Overrun <= 1'b1;
      end
      if (accept) begin
        audioR   <= AudioIn;
        tapR     <= TapValid ? $signed({TapIn, 4'b0}) : '0;
        wetGainR <= WetGain;
        fbGainR  <= FeedbackGain;
      end
      if (state == MUL_WET) begin
        wetP <= mulOut;
      end
      if (state == MUL_FB) begin
        fbP <= mulOut;
      end
      if (state == SUM) begin
        AudioOut  <= satWet;
        WriteData <= 16'(satFb >> 4);
        ClipFlag  <= clipWet | clipFb;
        OutValid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_delay_tap_mixer.sv
// Bench for delay_tap_mixer: directed corner cases plus random
// samples against an integer-arithmetic reference model.
module tb_delay_tap_mixer;

  logic        CLOCK50 = 1'b0;
  logic        RESET;
  logic        SAMPLE_STB;
  logic [19:0] AudioIn;
  logic [15:0] TapIn;
  logic        TapValid;
  logic [7:0]  WetGain;
  logic [7:0]  FeedbackGain;
  logic [19:0] AudioOut;
  logic [15:0] WriteData;
  logic        OutValid;
  logic        ClipFlag;
  logic        Busy;
  logic        Overrun;

  int errors = 0;
  int checks = 0;

  bit          ovExp;
  logic [19:0] lastAo;
  logic [15:0] lastWd;
  logic        lastClip;

  delay_tap_mixer dut (
    .CLOCK50      (CLOCK50),
    .RESET        (RESET),
    .SAMPLE_STB   (SAMPLE_STB),
    .AudioIn      (AudioIn),
    .TapIn        (TapIn),
    .TapValid     (TapValid),
    .WetGain      (WetGain),
    .FeedbackGain (FeedbackGain),
    .AudioOut     (AudioOut),
    .WriteData    (WriteData),
    .OutValid     (OutValid),
    .ClipFlag     (ClipFlag),
    .Busy         (Busy),
    .Overrun      (Overrun)
  );

  always #5 CLOCK50 = ~CLOCK50;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v, output bit c);
    c = 1'b0;
    if (v > 524287) begin
      c = 1'b1;
      return 524287;
    end
    if (v < -524288) begin
      c = 1'b1;
      return -524288;
    end
    return v;
  endfunction

  // Reference: dry + floor(tap*16*gain/256), clamped to 20-bit signed
  task automatic model(input logic [19:0] a, input logic [15:0] t,
                       input logic tv, input logic [7:0] w,
                       input logic [7:0] f, output logic [19:0] ao,
                       output logic [15:0] wd, output logic clip);
    int dry, tap, s1, s2;
    bit c1, c2;
    dry = int'($signed(a));
    tap = tv ? int'($signed(t)) * 16 : 0;
    s1 = clamp(dry + ((tap * int'(w)) >>> 8), c1);
    s2 = clamp(dry + ((tap * int'(f)) >>> 8), c2);
    ao = s1[19:0];
    wd = s2[19:4];
    clip = c1 | c2;
  endtask

  // Strobe at edge N, leaves the bench at the negedge after edge N+3
  task automatic runSample(input logic [19:0] a, input logic [15:0] t,
                           input logic tv, input logic [7:0] w,
                           input logic [7:0] f, input bit extra);
    logic [19:0] eAo;
    logic [15:0] eWd;
    logic        eClip;
    model(a, t, tv, w, f, eAo, eWd, eClip);
    AudioIn = a;
    TapIn = t;
    TapValid = tv;
    WetGain = w;
    FeedbackGain = f;
    SAMPLE_STB = 1'b1;
    @(negedge CLOCK50);
    SAMPLE_STB = 1'b0;
    AudioIn = 20'($urandom);
    TapIn = 16'($urandom);
    TapValid = 1'($urandom);
    WetGain = 8'($urandom);
    FeedbackGain = 8'($urandom);
    chk("busyN", Busy, 1);
    chk("validN", OutValid, 0);
    chk("holdAudioOut", AudioOut, lastAo);
    chk("holdWriteData", WriteData, lastWd);
    chk("holdClip", ClipFlag, lastClip);
    @(negedge CLOCK50);
    chk("validN1", OutValid, 0);
    if (extra) SAMPLE_STB = 1'b1;
    @(negedge CLOCK50);
    SAMPLE_STB = 1'b0;
    if (extra) ovExp = 1'b1;
    chk("validN2", OutValid, 0);
    chk("overrun", Overrun, ovExp);
    @(negedge CLOCK50);
    chk("validN3", OutValid, 1);
    chk("AudioOut", AudioOut, eAo);
    chk("WriteData", WriteData, eWd);
    chk("ClipFlag", ClipFlag, eClip);
    chk("busyIdle", Busy, 0);
    lastAo = eAo;
    lastWd = eWd;
    lastClip = eClip;
  endtask

  initial begin
    RESET = 1'b1;
    SAMPLE_STB = 1'b0;
    AudioIn = '0;
    TapIn = '0;
    TapValid = 1'b0;
    WetGain = '0;
    FeedbackGain = '0;
    ovExp = 1'b0;
    lastAo = '0;
    lastWd = '0;
    lastClip = 1'b0;
    repeat (2) @(negedge CLOCK50);
    chk("rstAudioOut", AudioOut, 0);
    chk("rstWriteData", WriteData, 0);
    chk("rstValid", OutValid, 0);
    chk("rstClip", ClipFlag, 0);
    chk("rstBusy", Busy, 0);
    chk("rstOverrun", Overrun, 0);
    RESET = 1'b0;
    @(negedge CLOCK50);

    runSample(20'h12345, 16'h7FFF, 1'b1, 8'd0, 8'd0, 1'b0);
    runSample(20'h10000, 16'h1000, 1'b1, 8'd128, 8'd64, 1'b0);
    runSample(20'h7FFFF, 16'h7FFF, 1'b1, 8'd255, 8'd0, 1'b0);
    runSample(20'h80000, 16'h8000, 1'b1, 8'd255, 8'd0, 1'b0);
    runSample(20'hFFF00, 16'h4000, 1'b0, 8'd255, 8'd255, 1'b0);
    @(negedge CLOCK50);
    chk("validDrop", OutValid, 0);

    for (int i = 0; i < 40; i++) begin
      logic [19:0] a;
      logic [15:0] t;
      logic [7:0]  w;
      logic [7:0]  f;
      a = 20'($urandom);
      t = 16'($urandom);
      w = 8'($urandom);
      f = 8'($urandom);
      if ($urandom_range(3) == 0) a = a[19] ? 20'h80000 : 20'h7FFFF;
      if ($urandom_range(3) == 0) w = 8'd255;
      if ($urandom_range(5) == 0) f = 8'd0;
      runSample(a, t, 1'($urandom_range(7) != 0), w, f, 1'b0);
    end

    runSample(20'h00100, 16'h0200, 1'b1, 8'd100, 8'd200, 1'b1);
    runSample(20'hF0000, 16'hC000, 1'b1, 8'd50, 8'd77, 1'b0);
    @(negedge CLOCK50);
    chk("overrunSticky", Overrun, 1);

    AudioIn = 20'h33333;
    TapIn = 16'h1111;
    TapValid = 1'b1;
    WetGain = 8'd200;
    FeedbackGain = 8'd200;
    SAMPLE_STB = 1'b1;
    @(negedge CLOCK50);
    SAMPLE_STB = 1'b0;
    @(negedge CLOCK50);
    RESET = 1'b1;
    #1;
    chk("midRstAudioOut", AudioOut, 0);
    chk("midRstWriteData", WriteData, 0);
    chk("midRstClip", ClipFlag, 0);
    chk("midRstBusy", Busy, 0);
    chk("midRstOverrun", Overrun, 0);
    @(negedge CLOCK50);
    RESET = 1'b0;
    ovExp = 1'b0;
    lastAo = '0;
    lastWd = '0;
    lastClip = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK50);
      chk("noValidAfterRst", OutValid, 0);
    end
    runSample(20'h10000, 16'h1000, 1'b1, 8'd128, 8'd64, 1'b0);
    @(negedge CLOCK50);
    chk("finalOverrun", Overrun, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
